// File: rtl/lowpass_decimate2_pack.sv
// Decimate-by-2 packer behind the 8-sample/clk lowpass filter.
// Saturates the even samples from 13 to 12 bits, packs two input clocks
// (4 kept samples each) into one 8-sample word and queues it in a small FIFO
// with a registered head, presented as a valid/ready stream.
module lowpass_decimate2_pack #(
  parameter int INBITS     = 13,
  parameter int OUTBITS    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTBITS    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0][INBITS-1:0]    dat_i,
  input  logic                      sync_i,
  output logic [7:0][OUTBITS-1:0]   m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      overflow_o,
  output logic [CNTBITS-1:0]        sat_cnt_o,
  input  logic                      clear_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [OUTBITS-1:0] sat_sample(input logic signed [INBITS-1:0] d);
    if (d[INBITS-1] == d[INBITS-2]) sat_sample = d[OUTBITS-1:0];
    else if (d[INBITS-1])           sat_sample = {1'b1, {(OUTBITS-1){1'b0}}};
    else                            sat_sample = {1'b0, {(OUTBITS-1){1'b1}}};
  endfunction

  function automatic logic is_clip(input logic signed [INBITS-1:0] d);
    is_clip = d[INBITS-1] ^ d[INBITS-2];
  endfunction

  function automatic logic [CNTBITS-1:0] sat_add(input logic [CNTBITS-1:0] a,
                                                 input logic [2:0]         b);
    logic [CNTBITS:0] s;
    s = {1'b0, a} + {{(CNTBITS-2){1'b0}}, b};
    sat_add = s[CNTBITS] ? {CNTBITS{1'b1}} : s[CNTBITS-1:0];
  endfunction

  // Odd samples are discarded by the decimation.
  logic unused_odd;
  assign unused_odd = ^{dat_i[1], dat_i[3], dat_i[5], dat_i[7]};

  logic [3:0][OUTBITS-1:0] sat_s;
  logic [2:0]              ev_s;
  logic                    ph;
  logic [3:0][OUTBITS-1:0] smp_p0;
  logic                    vld_p0;
  logic                    ph_p0;
  logic [3:0][OUTBITS-1:0] lo_p1;
  logic                    lo_vld_p1;

  // Saturate the kept samples and count clipped ones.
  always_comb begin
    sat_s = '0;
    ev_s  = '0;
    for (int j = 0; j < 4; j++) begin
      sat_s[j] = sat_sample(dat_i[2*j]);
      ev_s     = ev_s + 3'(is_clip(dat_i[2*j]));
    end
  end

  // ---- stage S boundary: saturated samples registered (p0) ----
  // Saturated sample data (no reset needed).
  always_ff @(posedge clk_i) begin
    smp_p0 <= sat_s;
  end

  // Phase counter and pack bookkeeping; sync restarts phase and drops partials.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph        <= 1'b0;
      vld_p0    <= 1'b0;
      ph_p0     <= 1'b0;
      lo_vld_p1 <= 1'b0;
    end else begin
      ph     <= sync_i ? 1'b0 : ~ph;
      vld_p0 <= ~sync_i;
      ph_p0  <= ph;
      if (sync_i)                lo_vld_p1 <= 1'b0;
      else if (vld_p0 && !ph_p0) lo_vld_p1 <= 1'b1;
      else if (vld_p0 && ph_p0)  lo_vld_p1 <= 1'b0;
    end
  end

  // ---- pack boundary: phase-0 half held (p1), word completed on phase 1 ----
  // Capture the phase-0 half of the word.
  always_ff @(posedge clk_i) begin
    if (vld_p0 && !ph_p0) lo_p1 <= smp_p0;
  end

  logic                       push;
  logic [7:0][OUTBITS-1:0]    push_word;
  logic [OUTBITS*8-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              mcnt;
  logic                       pop, load, full, wr_en, drop;

  assign push      = vld_p0 & ph_p0 & lo_vld_p1;
  assign push_word = {smp_p0, lo_p1};
  assign pop       = m_tvalid & m_tready;
  assign load      = (!m_tvalid || pop) && (mcnt != '0);
  // Occupancy counts the head register, so FIFO_DEPTH words fit in total.
  assign full      = (mcnt + CW'(m_tvalid)) == CW'(FIFO_DEPTH);
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // ---- FIFO boundary: storage written, head register reloads next edge ----
  // Word storage.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mcnt     <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr   <= rd_ptr + 1'b1;
        m_tdata  <= mem[rd_ptr];
        m_tvalid <= 1'b1;
      end else if (pop) begin
        m_tvalid <= 1'b0;
      end
      mcnt <= mcnt + CW'(wr_en) - CW'(load);
    end
  end

  // Sticky drop flag and clamped saturation counter; new events beat clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      sat_cnt_o  <= '0;
    end else begin
      if (clear_i) begin
        overflow_o <= drop;
        sat_cnt_o  <= sat_add('0, ev_s);
      end else begin
        if (drop) overflow_o <= 1'b1;
        sat_cnt_o <= sat_add(sat_cnt_o, ev_s);
      end
    end
  end

endmodule

// File: tb/tb_lowpass_decimate2_pack.sv
// Directed bench for lowpass_decimate2_pack (CNTBITS=4, FIFO_DEPTH=4).
module tb_lowpass_decimate2_pack;

  typedef logic [7:0][11:0] word_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [7:0][12:0]  dat_i;
  logic              sync_i;
  word_t             m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              overflow_o;
  logic [3:0]        sat_cnt_o;
  logic              clear_i;

  int total = 0;
  int bad   = 0;

  lowpass_decimate2_pack #(
    .INBITS(13), .OUTBITS(12), .FIFO_DEPTH(4), .CNTBITS(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .sync_i(sync_i),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .overflow_o(overflow_o), .sat_cnt_o(sat_cnt_o), .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t ramp_word(input int m);
    word_t w;
    for (int i = 0; i < 8; i++) w[i] = 12'(16*m + 2*i);
    return w;
  endfunction

  function automatic word_t halves(input logic [11:0] a, input logic [11:0] b);
    word_t w;
    for (int i = 0; i < 8; i++) w[i] = (i < 4) ? a : b;
    return w;
  endfunction

  task automatic set_ramp(input int n);
    for (int k = 0; k < 8; k++) dat_i[k] = 13'(k + 8*n);
  endtask

  task automatic set_all(input logic [12:0] v);
    for (int k = 0; k < 8; k++) dat_i[k] = v;
  endtask

  // Reset, then release with sync_i high so the following edge is the sync edge E.
  task automatic reset_sync();
    rst_i = 1'b1; sync_i = 1'b1; clear_i = 1'b0; set_all(13'h0);
    tick();
    rst_i = 1'b0;
    tick();
    sync_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; sync_i = 1'b0; clear_i = 1'b0; m_tready = 1'b1; set_all(13'h0);
    tick(); tick();
    chk("rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_tdata", 128'(m_tdata), 128'(0));
    chk("rst_ovf", 128'(overflow_o), 128'(0));
    chk("rst_satcnt", 128'(sat_cnt_o), 128'(0));

    // Ramp: first word 4 clocks after sync, then tvalid toggles.
    reset_sync();
    for (int i = 1; i <= 10; i++) begin
      set_ramp(i - 1);
      tick();
      if (i >= 4 && (i % 2) == 0) begin
        chk("ramp_tvalid", 128'(m_tvalid), 128'(1));
        chk("ramp_tdata", 128'(m_tdata), 128'(ramp_word((i - 4) / 2)));
      end else begin
        chk("ramp_tvalid_lo", 128'(m_tvalid), 128'(0));
      end
    end
    chk("ramp_satcnt", 128'(sat_cnt_o), 128'(0));

    // Saturation: only even samples count, clip both ways, in-range negatives pass.
    reset_sync();
    set_all(13'h0FFF);
    tick();
    chk("sat_pos_cnt", 128'(sat_cnt_o), 128'(4));
    set_all(13'h1000);
    tick();
    chk("sat_neg_cnt", 128'(sat_cnt_o), 128'(8));
    for (int k = 0; k < 8; k++) dat_i[k] = (k % 2 == 0) ? 13'h1FFF : 13'h0FFF;
    tick();
    chk("sat_noclip_cnt", 128'(sat_cnt_o), 128'(8));
    set_all(13'h0);
    tick();
    chk("sat_word1", 128'(m_tdata), 128'(halves(12'h7FF, 12'h800)));
    tick();
    tick();
    chk("sat_word2", 128'(m_tdata), 128'(halves(12'hFFF, 12'h000)));
    chk("sat_word2_vld", 128'(m_tvalid), 128'(1));

    // Counter clamp at all-ones, then clear racing with events.
    set_all(13'h0FFF);
    tick();
    chk("clamp_12", 128'(sat_cnt_o), 128'(12));
    tick();
    chk("clamp_15", 128'(sat_cnt_o), 128'(15));
    tick();
    chk("clamp_hold", 128'(sat_cnt_o), 128'(15));
    set_all(13'h0);
    dat_i[0] = 13'h1000;
    dat_i[2] = 13'h1000;
    clear_i = 1'b1;
    tick();
    chk("clear_vs_evt", 128'(sat_cnt_o), 128'(2));
    set_all(13'h0);
    tick();
    chk("clear_plain", 128'(sat_cnt_o), 128'(0));
    clear_i = 1'b0;

    // Backpressure: 4 words held, 5th dropped, drain in order, clear flag.
    reset_sync();
    m_tready = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      set_ramp(i - 1);
      tick();
      if (i == 4)  chk("bp_head", 128'(m_tdata), 128'(ramp_word(0)));
      if (i == 10) chk("bp_no_ovf", 128'(overflow_o), 128'(0));
      if (i == 11) begin
        chk("bp_ovf", 128'(overflow_o), 128'(1));
        chk("bp_stable", 128'(m_tdata), 128'(ramp_word(0)));
      end
    end
    sync_i = 1'b1;
    m_tready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk("bp_drain", 128'(m_tdata), 128'(ramp_word(j)));
    end
    tick();
    chk("bp_empty", 128'(m_tvalid), 128'(0));
    chk("bp_ovf_sticky", 128'(overflow_o), 128'(1));
    clear_i = 1'b1;
    tick();
    chk("bp_ovf_clr", 128'(overflow_o), 128'(0));
    clear_i = 1'b0;

    // Full FIFO with pop on the push edge: no overflow, 4 words remain.
    reset_sync();
    m_tready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_ramp(i - 1);
      tick();
    end
    chk("full_head", 128'(m_tdata), 128'(ramp_word(0)));
    set_ramp(10);
    m_tready = 1'b1;
    tick();
    chk("full_pp_ovf", 128'(overflow_o), 128'(0));
    chk("full_pp_head", 128'(m_tdata), 128'(ramp_word(1)));
    m_tready = 1'b0;
    sync_i = 1'b1;
    tick();
    chk("full_hold", 128'(m_tdata), 128'(ramp_word(1)));
    m_tready = 1'b1;
    for (int j = 2; j <= 4; j++) begin
      tick();
      chk("full_drain", 128'(m_tdata), 128'(ramp_word(j)));
    end
    tick();
    chk("full_empty", 128'(m_tvalid), 128'(0));
    sync_i = 1'b0;

    // Sync after a phase-0 clock discards the partial pack.
    reset_sync();
    for (int i = 1; i <= 8; i++) begin
      set_ramp(i - 1);
      sync_i = (i == 4);
      tick();
      if (i == 4) chk("sync_word0", 128'(m_tdata), 128'(ramp_word(0)));
      if (i >= 5 && i <= 7) chk("sync_gap", 128'(m_tvalid), 128'(0));
      if (i == 8) begin
        chk("sync_vld", 128'(m_tvalid), 128'(1));
        chk("sync_word", 128'(m_tdata), 128'(ramp_word(2)));
      end
    end
    sync_i = 1'b0;

    // Asynchronous reset between edges, then a full phase pair before output.
    reset_sync();
    m_tready = 1'b0;
    set_all(13'h0FFF);
    for (int i = 1; i <= 5; i++) tick();
    chk("ar_pre_vld", 128'(m_tvalid), 128'(1));
    chk("ar_pre_cnt", 128'(sat_cnt_o), 128'(15));
    #3;
    rst_i = 1'b1;
    #1;
    chk("ar_tvalid", 128'(m_tvalid), 128'(0));
    chk("ar_tdata", 128'(m_tdata), 128'(0));
    chk("ar_ovf", 128'(overflow_o), 128'(0));
    chk("ar_cnt", 128'(sat_cnt_o), 128'(0));
    tick();
    rst_i = 1'b0;
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_ramp(i - 1);
      tick();
      if (i < 4) chk("ar_wait", 128'(m_tvalid), 128'(0));
      else begin
        chk("ar_vld", 128'(m_tvalid), 128'(1));
        chk("ar_word", 128'(m_tdata), 128'(ramp_word(0)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
